// File: rtl/keccak_pad_buf.sv
// Keccak absorb-side buffer: packs 32-bit message words into a rate-sized
// block, applies SHA3/SHAKE pad10*1 and hands whole blocks to the
// permutation core with a valid/ack handshake.

// One byte lane of the input word. It extracts the lane's byte (lane 0 is
// din[31:24], the lowest address) and decides whether that byte is written.
// In a final word only the first n bytes are real message data.
module keccak_pad_lane #(
  parameter int LANE = 0
) (
  input  logic [31:0] din,
  input  logic        last,
  input  logic [2:0]  n,
  output logic [7:0]  data,
  output logic        we
);
  assign data = din[31-8*LANE -: 8];
  assign we   = !last || (3'(LANE) < n);
endmodule

module keccak_pad_buf #(
  parameter int NUM_LANES = 4,
  parameter int RMAX      = 168
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmode,
  input  logic [31:0]       din,
  input  logic              din_valid,
  input  logic              din_last,
  input  logic [2:0]        din_nbytes,
  output logic              din_ready,
  output logic [RMAX*8-1:0] blk_o,
  output logic              blk_valid,
  output logic              blk_last,
  input  logic              blk_ack
);

  typedef enum logic [1:0] {FILL, OUT, EXTRA} state_t;

  state_t                     state_q, state_d;
  logic [5:0]                 wcnt_q, wcnt_d;
  logic                       pad_pend_q, pad_pend_d;
  logic                       last_q, last_d;
  logic                       busy_q, busy_d;
  logic [2:0]                 mode_q, mode_d;
  logic [RMAX-1:0][7:0]       buf_q, buf_d;

  logic                       mode_ok;
  logic                       first;
  logic [2:0]                 eff_mode;
  logic [7:0]                 rate;
  logic [7:0]                 rate_m1;
  logic [5:0]                 last_w;
  logic [7:0]                 sfx;
  logic                       accept;
  logic [2:0]                 n_cl;
  logic [7:0]                 base;
  logic [7:0]                 pad_pos;
  logic [NUM_LANES-1:0][7:0]  lane_data;
  logic [NUM_LANES-1:0]       lane_we;

  // Rate in bytes; invalid modes give 0 but never get past din_ready.
  function automatic logic [7:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    rate_of = 8'd144;
      3'd1:    rate_of = 8'd136;
      3'd2:    rate_of = 8'd104;
      3'd3:    rate_of = 8'd72;
      3'd4:    rate_of = 8'd168;
      3'd5:    rate_of = 8'd136;
      default: rate_of = 8'd0;
    endcase
  endfunction

  // Domain-separation suffix: SHA3 vs SHAKE.
  function automatic logic [7:0] suffix_of(input logic [2:0] m);
    suffix_of = (m >= 3'd4) ? 8'h1F : 8'h06;
  endfunction

  // Until the first word of a message is taken the live cmode decides the
  // rate; from then on the latched copy does, so a cmode change mid-message
  // (including across full-block boundaries) cannot corrupt the geometry.
  assign mode_ok   = (cmode <= 3'd5);
  assign first     = (state_q == FILL) && !busy_q;
  assign eff_mode  = first ? cmode : mode_q;
  assign rate      = rate_of(eff_mode);
  assign rate_m1   = rate - 8'd1;
  assign last_w    = rate[7:2] - 6'd1;
  assign sfx       = suffix_of(eff_mode);

  assign din_ready = (state_q == FILL) && mode_ok;
  assign accept    = din_valid && din_ready;
  assign n_cl      = (din_nbytes > 3'd4) ? 3'd4 : din_nbytes;
  assign base      = {wcnt_q, 2'b00};
  assign pad_pos   = base + {5'd0, n_cl};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      keccak_pad_lane #(.LANE(g)) u_lane (
        .din  (din),
        .last (din_last),
        .n    (n_cl),
        .data (lane_data[g]),
        .we   (lane_we[g])
      );
    end
  endgenerate

  // Next-state, word packing, padding and handshake.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pad_pend_d = pad_pend_q;
    last_d     = last_q;
    busy_d     = busy_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          busy_d = 1'b1;
          if (!busy_q) mode_d = cmode;
          for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_we[k]) buf_d[base + 8'(k)] = lane_data[k];
          end
          if (din_last) begin
            state_d = OUT;
            if (pad_pos < rate) begin
              // Pad byte lies in an unwritten (zero) slot; when p == R-1
              // the two XORs merge into suffix|0x80.
              buf_d[pad_pos] = buf_d[pad_pos] ^ sfx;
              buf_d[rate_m1] = buf_d[rate_m1] ^ 8'h80;
              last_d         = 1'b1;
            end else begin
              // Block exactly full: padding needs a block of its own.
              pad_pend_d = 1'b1;
              last_d     = 1'b0;
            end
          end else if (wcnt_q == last_w) begin
            state_d = OUT;
            last_d  = 1'b0;
          end else begin
            wcnt_d = wcnt_q + 6'd1;
          end
        end
      end
      OUT: begin
        if (blk_ack) begin
          buf_d   = '0;
          wcnt_d  = '0;
          last_d  = 1'b0;
          if (last_q) busy_d = 1'b0;
          state_d = pad_pend_q ? EXTRA : FILL;
        end
      end
      EXTRA: begin
        buf_d[0]       = sfx;
        buf_d[rate_m1] = buf_d[rate_m1] | 8'h80;
        pad_pend_d     = 1'b0;
        last_d         = 1'b1;
        state_d        = OUT;
      end
      default: state_d = FILL;
    endcase
  end

  // State and buffer registers; reset drops any partial or pending block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      pad_pend_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      mode_q     <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pad_pend_q <= pad_pend_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      buf_q      <= buf_d;
    end
  end

  assign blk_o     = buf_q;
  assign blk_valid = (state_q == OUT);
  assign blk_last  = last_q;

endmodule

// File: tb/tb_keccak_pad_buf.sv
// Self-checking bench for keccak_pad_buf: messages are padded by a
// byte-level pad10*1 model and compared block by block.
module tb_keccak_pad_buf;

  typedef logic [1343:0] blk_t;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cmode;
  logic [31:0] din;
  logic        din_valid;
  logic        din_last;
  logic [2:0]  din_nbytes;
  logic        din_ready;
  blk_t        blk_o;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_ack;

  int n_chk  = 0;
  int n_fail = 0;

  blk_t exp_q[$];
  bit   exp_last_q[$];

  always #5 clk = ~clk;

  keccak_pad_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmode      (cmode),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_nbytes (din_nbytes),
    .din_ready  (din_ready),
    .blk_o      (blk_o),
    .blk_valid  (blk_valid),
    .blk_last   (blk_last),
    .blk_ack    (blk_ack)
  );

  function automatic int rate_of(input int m);
    case (m)
      0: return 144; 1: return 136; 2: return 104;
      3: return 72;  4: return 168; default: return 136;
    endcase
  endfunction

  // Reference: message || suffix || 0* || 0x80 (last byte), split into rate blocks.
  task automatic build_exp(input int m, input bq_t msg);
    int r = rate_of(m);
    int len = msg.size();
    int nb = len / r + 1;
    logic [7:0] pad[];
    blk_t v;
    pad = new[nb * r];
    foreach (pad[i]) pad[i] = 8'h00;
    for (int i = 0; i < len; i++) pad[i] = msg[i];
    pad[len]        = pad[len] ^ ((m >= 4) ? 8'h1F : 8'h06);
    pad[nb * r - 1] = pad[nb * r - 1] ^ 8'h80;
    exp_q.delete();
    exp_last_q.delete();
    for (int b = 0; b < nb; b++) begin
      v = '0;
      for (int j = 0; j < r; j++) v[8*j +: 8] = pad[b*r + j];
      exp_q.push_back(v);
      exp_last_q.push_back(b == nb - 1);
    end
  endtask

  function automatic int first_bad(input blk_t a, input blk_t b);
    for (int j = 0; j < 168; j++) if (a[8*j +: 8] !== b[8*j +: 8]) return j;
    return -1;
  endfunction

  task automatic drive_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
    int t = 0;
    @(negedge clk);
    din = d; din_last = last; din_nbytes = nb; din_valid = 1'b1;
    while (!din_ready && t < 1000) begin @(negedge clk); t++; end
    n_chk++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drive_word_timeout: din_ready=%0b required 1", din_ready);
    end
    @(posedge clk);
  endtask

  task automatic drive_msg(input bq_t msg, input bit tail_empty, input int gap_max);
    int len = msg.size();
    bit et = (len == 0) || ((len % 4 == 0) && tail_empty);
    int nw = et ? len / 4 : (len + 3) / 4;
    logic [31:0] d;
    logic [2:0] nb;
    bit last;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++)
        d[31-8*k -: 8] = (4*w + k < len) ? msg[4*w + k] : 8'($urandom);
      last = !et && (w == nw - 1);
      if (len - 4*w >= 4) nb = last ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 7));
      else nb = 3'(len - 4*w);
      repeat ($urandom_range(0, gap_max)) begin @(negedge clk); din_valid = 1'b0; end
      drive_word(d, last, nb);
    end
    if (et) drive_word($urandom, 1'b1, 3'd0);
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic collect(input string tag, input int ack_max);
    int got = 0;
    int t = 0;
    int bad;
    blk_t held;
    while (got < exp_q.size() && t < 5000) begin
      @(negedge clk); t++;
      if (blk_valid) begin
        n_chk++;
        if (blk_o !== exp_q[got]) begin
          n_fail++; bad = first_bad(blk_o, exp_q[got]);
          $display("FAIL %s blk%0d byte%0d: got %02h required %02h", tag, got, bad,
                   blk_o[8*bad +: 8], exp_q[got][8*bad +: 8]);
        end
        n_chk++;
        if (blk_last !== exp_last_q[got]) begin
          n_fail++;
          $display("FAIL %s blk%0d blk_last: got %0b required %0b", tag, got, blk_last, exp_last_q[got]);
        end
        held = blk_o;
        repeat ($urandom_range(0, ack_max)) begin
          @(negedge clk);
          n_chk++;
          if (blk_o !== held || blk_valid !== 1'b1 || din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: valid=%0b ready=%0b stable=%0b required 1 0 1", tag,
                     blk_valid, din_ready, blk_o === held);
          end
        end
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
        got++;
        if (got == exp_q.size()) begin
          n_chk++;
          if (din_ready !== 1'b1 || blk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_ack: ready=%0b valid=%0b required 1 0", tag, din_ready, blk_valid);
          end
        end
      end
    end
    n_chk++;
    if (got != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s block_count: got %0d required %0d", tag, got, exp_q.size());
    end
  endtask

  task automatic run_msg(input string tag, input int m, input bq_t msg,
                         input bit tail_empty, input int gap_max, input int ack_max);
    cmode = 3'(m);
    build_exp(m, msg);
    fork
      drive_msg(msg, tail_empty, gap_max);
      collect(tag, ack_max);
    join
    repeat (2) @(negedge clk);
    n_chk++;
    if (blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s spurious_block: blk_valid=%0b required 0", tag, blk_valid);
    end
  endtask

  function automatic bq_t rand_bytes(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; cmode = 3'd1; din = '0; din_valid = 1'b0; din_last = 1'b0;
    din_nbytes = '0; blk_ack = 1'b0;
    #12;
    n_chk++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", blk_valid); end
    n_chk++; if (blk_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b required 0", blk_last); end
    n_chk++; if (blk_o !== '0) begin n_fail++; $display("FAIL reset_blk: nonzero, required 0"); end
    n_chk++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_valid_mode: got %0b required 1", din_ready); end
    cmode = 3'd6; #1;
    n_chk++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_mode6: got %0b required 0", din_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_invalid_mode;
    cmode = 3'd7;
    @(negedge clk); din = 32'hDEADBEEF; din_last = 1'b1; din_nbytes = 3'd4; din_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (din_ready !== 1'b0 || blk_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_mode: ready=%0b valid=%0b required 0 0", din_ready, blk_valid);
      end
    end
    din_valid = 1'b0;
    run_msg("after_invalid", 5, rand_bytes(9), 1'b0, 1, 1);
  endtask

  task automatic test_backpressure;
    bq_t m1 = '{8'hAA, 8'hBB};
    bq_t m2 = '{8'h11, 8'h22, 8'h33, 8'h44};
    blk_t held;
    cmode = 3'd1;
    build_exp(1, m1);
    drive_word(32'hAABB_5A5A, 1'b1, 3'd2);
    @(negedge clk);
    din = 32'h1122_3344; din_last = 1'b1; din_nbytes = 3'd4; din_valid = 1'b1;
    n_chk++;
    if (blk_valid !== 1'b1 || blk_o !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_block1: valid=%0b match=%0b required 1 1", blk_valid, blk_o === exp_q[0]);
    end
    held = blk_o;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if (blk_o !== held || blk_last !== 1'b1 || din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: stable=%0b last=%0b ready=%0b required 1 1 0", blk_o === held, blk_last, din_ready);
      end
    end
    blk_ack = 1'b1;
    @(negedge clk); blk_ack = 1'b0;
    n_chk++;
    if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_ack: got %0b required 1", din_ready); end
    build_exp(1, m2);
    @(negedge clk); din_valid = 1'b0;
    n_chk++;
    if (blk_valid !== 1'b1 || blk_o !== exp_q[0] || blk_last !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_block2: valid=%0b match=%0b last=%0b required 1 1 1", blk_valid, blk_o === exp_q[0], blk_last);
    end
    blk_ack = 1'b1;
    @(negedge clk); blk_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    cmode = 3'd0;
    for (int w = 0; w < 10; w++) drive_word($urandom, 1'b0, 3'd4);
    @(negedge clk); din_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_chk++;
    if (blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_o !== '0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b last=%0b zero=%0b ready=%0b required 0 0 1 1",
               blk_valid, blk_last, blk_o === '0, din_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    run_msg("reset_mid_empty", 0, rand_bytes(0), 1'b0, 0, 0);
  endtask

  task automatic test_boundaries;
    int ms[2] = '{0, 5};
    foreach (ms[i]) begin
      int r = rate_of(ms[i]);
      run_msg("bnd_r_m1", ms[i], rand_bytes(r - 1), 1'b0, 1, 1);
      run_msg("bnd_r",    ms[i], rand_bytes(r),     1'b0, 1, 1);
      run_msg("bnd_r_emp", ms[i], rand_bytes(r),    1'b1, 1, 1);
      run_msg("bnd_r_p1", ms[i], rand_bytes(r + 1), 1'b0, 1, 1);
      run_msg("bnd_2r",   ms[i], rand_bytes(2 * r), 1'b0, 1, 1);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      run_msg("random", $urandom_range(0, 5), rand_bytes($urandom_range(0, 400)),
              1'($urandom), 2, 3);
  endtask

  task automatic test_back_to_back;
    run_msg("b2b_0", 2, rand_bytes(104), 1'b0, 0, 0);
    run_msg("b2b_1", 2, rand_bytes(10),  1'b0, 0, 0);
    run_msg("b2b_2", 4, rand_bytes(3),   1'b0, 0, 0);
  endtask

  initial begin
    test_reset;
    run_msg("empty", 1, rand_bytes(0), 1'b0, 0, 0);
    run_msg("abc", 1, '{8'h61, 8'h62, 8'h63}, 1'b0, 0, 0);
    run_msg("exact_fill", 3, rand_bytes(72), 1'b0, 0, 2);
    run_msg("merged_pad", 4, rand_bytes(167), 1'b0, 0, 1);
    test_backpressure;
    test_reset_mid;
    test_invalid_mode;
    test_boundaries;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_pad_buf.md
KECCAK_PAD_BUF -- requirements
Module: keccak_pad_buf

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and the single clock; all state changes on its rising edge.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and the asynchronous active-low reset.
REQ-003 The port cmode SHALL be an input, 3 bits wide, encoded 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256, with 6 and 7 invalid.
REQ-004 The port din SHALL be an input, 32 bits wide, carrying message bytes; din[31:24] is the lowest-addressed byte.
REQ-005 The port din_valid SHALL be an input, 1 bit wide, indicating that din is valid.
REQ-006 The port din_last SHALL be an input, 1 bit wide, marking the final word of the message.
REQ-007 The port din_nbytes SHALL be an input, 3 bits wide, giving the valid bytes (0..4) in the last word; it is ignored unless din_last=1, and values 5..7 are treated as 4.
REQ-008 The port din_ready SHALL be an output, 1 bit wide, indicating that the block accepts a word.
REQ-009 The port blk_o SHALL be an output, 1344 bits wide, carrying the rate block; byte j is at blk_o[8j+7:8j] and bits at or above the rate are 0.
REQ-010 The port blk_valid SHALL be an output, 1 bit wide, indicating that blk_o is valid for the permutation core.
REQ-011 The port blk_last SHALL be an output, 1 bit wide, marking the final (padded) block of the message.
REQ-012 The port blk_ack SHALL be an input, 1 bit wide, by which the core consumes blk_o.

Function
REQ-013 The rate R SHALL be selected per mode as 144/136/104/72/168/136 bytes, i.e. W=36/34/26/18/42/34 words, for cmode 0..5.
REQ-014 cmode SHALL be latched when the first word of a message is accepted and held until the message's last block is acked.
REQ-015 The FSM SHALL have three states: FILL, OUT and EXTRA; the reset state is FILL.
REQ-016 In FILL, din_ready SHALL be 1 when cmode (live value before latching) is valid and 0 otherwise; in OUT and EXTRA it SHALL be 0.
REQ-017 A word SHALL be accepted when din_valid=1 and din_ready=1; its bytes are written to byte positions 4*wcnt..4*wcnt+3, where wcnt is a 6-bit word counter.
REQ-018 On a non-last accept with wcnt<W-1, the block SHALL increment wcnt and stay in FILL.
REQ-019 On a non-last accept with wcnt=W-1, the block SHALL go to OUT with blk_last=0.
REQ-020 On a last accept with n=din_nbytes, the padding position SHALL be p=4*wcnt+n.
REQ-021 If p<R, byte p SHALL be XORed with the suffix (0x06 for SHA3, 0x1F for SHAKE), byte R-1 SHALL be XORed with 0x80, and the state SHALL go to OUT with blk_last=1.
REQ-022 If p=R-1, that byte SHALL equal suffix|0x80, i.e. 0x86 or 0x9F.
REQ-023 If p=R (last word full, block full), the block SHALL go to OUT with blk_last=0 and set pad_pend.
REQ-024 Only the first n bytes of a last word SHALL be written; the remaining bytes of that word stay 0.
REQ-025 blk_valid SHALL equal (state==OUT), asserted the cycle after the accepting edge.
REQ-026 blk_o and blk_last SHALL be held stable while blk_valid=1 and blk_ack=0.
REQ-027 On blk_ack=1 in OUT, the buffer SHALL be cleared to 0 and wcnt set to 0.
REQ-028 On that ack, if pad_pend=1 the state SHALL go to EXTRA; otherwise it SHALL go to FILL, with din_ready high the next cycle.
REQ-029 EXTRA SHALL last one cycle: it writes suffix at byte 0 and 0x80 at byte R-1, clears pad_pend and goes to OUT with blk_last=1.
REQ-030 blk_ack SHALL be ignored outside OUT.
REQ-031 A din_valid while din_ready=0 SHALL not be consumed.
REQ-032 The end of a message SHALL require no idle cycle before the next message's first word is accepted in FILL.
REQ-033 The word sequence SHALL be byte-compatible with the downstream truncation stage: byte order in/out is identical.

Reset
REQ-034 When rst_n=0, the block SHALL asynchronously set state=FILL, wcnt=0, pad_pend=0, buffer=0, blk_valid=0, blk_last=0, blk_o=0 and latched mode=0.
REQ-035 din_ready SHALL be 1 while rst_n=0 only if cmode is valid; a reset mid-fill or in OUT discards the partial or pending block, and no block is emitted.

Verification
REQ-036 Empty-message scenario: SHA3-256, one word with din_last=1, nbytes=0 -> a single block with byte0=0x06, byte135=0x80, all others 0, blk_last=1.
REQ-037 "abc" scenario: SHA3-256, din=0x61626300, last, nbytes=3 -> bytes0..3 = 61 62 63 06, byte135=0x80, blk_last=1.
REQ-038 Exact-fill scenario: SHA3-512, 18 words with the 18th last and nbytes=4 -> block 1 (blk_last=0) is data only, then after ack block 2 is byte0=0x06, byte71=0x80, blk_last=1.
REQ-039 Merged-pad scenario: SHAKE128, 41 full words then a last word with nbytes=3 -> byte167=0x9F, blk_last=1, single block.
REQ-040 Backpressure scenario: hold blk_ack=0 for 5 cycles in OUT -> blk_o and blk_last stable, din_ready=0, din_valid words not consumed; on ack, din_ready=1 the next cycle.
REQ-041 Reset scenario: assert rst_n=0 after 10 words in SHA3-224 -> all outputs 0, then a new empty message yields byte0=0x06, byte143=0x80.
